// File: rtl/alu_result_packer_if.sv
// Handshake bundle between the ALU result stage, the packer and the UART TX FIFO.
// slave = packer side, master = ALU/FIFO side driving the packer.
interface alu_result_packer_if #(
   parameter int BYTE_WIDTH = 8,
   parameter int OUT_WIDTH  = 16
);
   logic [OUT_WIDTH-1:0]  alu_out;
   logic                  out_valid;
   logic                  tx_ready;
   logic [BYTE_WIDTH-1:0] tx_data;
   logic                  tx_valid;
   logic                  busy;
   logic                  overflow;
   logic                  clr_ovf;

   modport slave (
      input  alu_out, out_valid, tx_ready, clr_ovf,
      output tx_data, tx_valid, busy, overflow
   );

   modport master (
      output alu_out, out_valid, tx_ready, clr_ovf,
      input  tx_data, tx_valid, busy, overflow
   );
endinterface

// File: rtl/alu_result_packer.sv
// Packs 16-bit ALU results into a low-byte-first byte stream with one pending slot.
// Optional macro ALU_PACKER_CHECKSUM_EN appends a low^high checksum byte per result.
//
// state   | meaning
// --------+----------------------------------------------
// IDLE    | no active result, tx_valid low
// SEND_LO | offering act[BYTE_WIDTH-1:0]
// SEND_HI | offering act[OUT_WIDTH-1:BYTE_WIDTH]
// SEND_CK | offering low^high checksum (macro builds only)
module alu_result_packer #(
   parameter int BYTE_WIDTH = 8,
   parameter int OUT_WIDTH  = 16
) (
   input  logic                clk,
   input  logic                rst,
   alu_result_packer_if.slave  bus
);

   if (OUT_WIDTH != 2*BYTE_WIDTH) begin : g_width_chk
      $error("alu_result_packer: OUT_WIDTH must equal 2*BYTE_WIDTH");
   end

`ifdef ALU_PACKER_CHECKSUM_EN
   typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI, SEND_CK} state_t;
   localparam state_t LAST_ST = SEND_CK;
`else
   typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} state_t;
   localparam state_t LAST_ST = SEND_HI;
`endif

   state_t                state_q, state_d;
   logic [OUT_WIDTH-1:0]  act_q, act_d;
   logic [OUT_WIDTH-1:0]  pend_q, pend_d;
   logic                  pend_v_q, pend_v_d;
   logic                  ovf_q, ovf_d;
   logic                  tx_valid_q, tx_valid_d;
   logic [BYTE_WIDTH-1:0] tx_data_q, tx_data_d;
   logic                  busy_q, busy_d;

   logic xfer, last_xfer, promote, direct, drop;

   always_comb begin
      state_d  = state_q;
      act_d    = act_q;
      pend_d   = pend_q;
      pend_v_d = pend_v_q;
      drop     = 1'b0;

      xfer      = tx_valid_q & bus.tx_ready;
      last_xfer = xfer & (state_q == LAST_ST);
      promote   = last_xfer & pend_v_q;
      // A new result goes straight to ACT when nothing else will occupy it next cycle.
      direct    = (state_q == IDLE) | (last_xfer & ~pend_v_q);

      case (state_q)
         IDLE: begin
            if (bus.out_valid) begin
               act_d   = bus.alu_out;
               state_d = SEND_LO;
            end
         end
         SEND_LO: begin
            if (xfer) state_d = SEND_HI;
         end
`ifdef ALU_PACKER_CHECKSUM_EN
         SEND_HI: begin
            if (xfer) state_d = SEND_CK;
         end
`endif
         default: ;
      endcase

      if (last_xfer) begin
         if (pend_v_q) begin
            act_d   = pend_q;
            state_d = SEND_LO;
         end else if (bus.out_valid) begin
            act_d   = bus.alu_out;
            state_d = SEND_LO;
         end else begin
            state_d = IDLE;
         end
      end

      if (bus.out_valid && !direct) begin
         if (!pend_v_q || promote) begin
            pend_d   = bus.alu_out;
            pend_v_d = 1'b1;
         end else begin
            drop = 1'b1;
         end
      end else if (promote) begin
         pend_v_d = 1'b0;
      end

      ovf_d = drop | (ovf_q & ~bus.clr_ovf);

      tx_valid_d = (state_d != IDLE);
      busy_d     = tx_valid_d | pend_v_d;

      case (state_d)
         SEND_LO: tx_data_d = act_d[BYTE_WIDTH-1:0];
         SEND_HI: tx_data_d = act_d[OUT_WIDTH-1:BYTE_WIDTH];
`ifdef ALU_PACKER_CHECKSUM_EN
         SEND_CK: tx_data_d = act_d[BYTE_WIDTH-1:0] ^ act_d[OUT_WIDTH-1:BYTE_WIDTH];
`endif
         default: tx_data_d = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         act_q      <= '0;
         pend_q     <= '0;
         pend_v_q   <= 1'b0;
         ovf_q      <= 1'b0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         act_q      <= act_d;
         pend_q     <= pend_d;
         pend_v_q   <= pend_v_d;
         ovf_q      <= ovf_d;
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.tx_valid = tx_valid_q;
   assign bus.tx_data  = tx_data_q;
   assign bus.busy     = busy_q;
   assign bus.overflow = ovf_q;

endmodule
